audio_level_meter: RTL

- Per-channel PCM level meter running in the video clock domain. Feeds the bar-overlay stage, which sits between the VGA core and hdmi_tx.
- Takes the 16-bit L/R PCM stream and its fs strobe, which arrive from the 128fs audio clock domain.
- Tracks the per-video-frame peak magnitude with frame-based decay and peak-hold.
- Publishes 8-bit level and peak values once per frame, on the falling edge of vsync_n.

---
 rtl/audio_level_meter.sv | 119 +++++++++++
 1 files changed

// File: rtl/audio_level_meter.sv
// Per-channel PCM level meter: tracks |sample| peaks from an asynchronous fs strobe and
// publishes decaying level and peak-hold values once per video frame (vsync_n fall).
module audio_level_meter #(
   parameter int unsigned DECAY_STEP  = 4,
   parameter int unsigned HOLD_FRAMES = 30
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               mute,
   input  logic               pcm_fs,
   input  logic signed [15:0] pcm_l_in,
   input  logic signed [15:0] pcm_r_in,
   input  logic               vsyncn_in,
   output logic [7:0]         level_l,
   output logic [7:0]         level_r,
   output logic [7:0]         peak_l,
   output logic [7:0]         peak_r,
   output logic               level_valid
);

   localparam logic [7:0] STEP = 8'(DECAY_STEP);
   localparam logic [7:0] HOLD = 8'(HOLD_FRAMES);

   function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
      return (a > b) ? (a - b) : 8'd0;
   endfunction

   function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
      return (a > b) ? a : b;
   endfunction

   // |x| with -32768 clamped to 32767, then scaled to 8 bits
   function automatic logic [7:0] sample_mag(input logic signed [15:0] x);
      logic [15:0] m;
      if (x == 16'sh8000)
         m = 16'h7fff;
      else if (x < 16'sd0)
         m = 16'(-x);
      else
         m = 16'(x);
      return m[14:7];
   endfunction

   logic               fs_p0, fs_p1, fs_p2;
   logic               vs_p0;
   logic               fs_stb, frm;
   logic signed [15:0] pcm   [2];
   logic [7:0]         mag   [2];
   logic [7:0]         nl    [2];
   logic [7:0]         acc   [2];
   logic [7:0]         level [2];
   logic [7:0]         peak  [2];
   logic [7:0]         hold  [2];

   assign pcm[0] = pcm_l_in;
   assign pcm[1] = pcm_r_in;

   assign fs_stb = fs_p1 & ~fs_p2;
   assign frm    = vs_p0 & ~vsyncn_in;

   always_comb begin
      for (int c = 0; c < 2; c++) begin
         mag[c] = mute ? 8'd0 : sample_mag(pcm[c]);
         nl[c]  = max8(acc[c], sat_sub(level[c], STEP));
      end
   end

   // Stage p0..p2: fs synchronizer and edge history; vsync history
   always_ff @(posedge clk) begin
      if (reset) begin
         fs_p0 <= 1'b1;
         fs_p1 <= 1'b1;
         fs_p2 <= 1'b1;
         vs_p0 <= 1'b1;
      end else begin
         fs_p0 <= pcm_fs;
         fs_p1 <= fs_p0;
         fs_p2 <= fs_p1;
         vs_p0 <= vsyncn_in;
      end
   end

   // Accumulate / frame close: a colliding sample seeds the next frame's accumulator
   always_ff @(posedge clk) begin
      if (reset) begin
         level_valid <= 1'b0;
         for (int c = 0; c < 2; c++) begin
            acc[c]   <= 8'd0;
            level[c] <= 8'd0;
            peak[c]  <= 8'd0;
            hold[c]  <= 8'd0;
         end
      end else begin
         level_valid <= frm;
         for (int c = 0; c < 2; c++) begin
            if (frm) begin
               level[c] <= nl[c];
               acc[c]   <= fs_stb ? mag[c] : 8'd0;
               if (nl[c] >= peak[c]) begin
                  peak[c] <= nl[c];
                  hold[c] <= HOLD;
               end else if (hold[c] != 8'd0) begin
                  hold[c] <= hold[c] - 8'd1;
               end else begin
                  peak[c] <= max8(nl[c], sat_sub(peak[c], STEP));
               end
            end else if (fs_stb) begin
               acc[c] <= max8(acc[c], mag[c]);
            end
         end
      end
   end

   assign level_l = level[0];
   assign level_r = level[1];
   assign peak_l  = peak[0];
   assign peak_r  = peak[1];

endmodule
